// File: rtl/mem_port_arbiter_pkg.sv
// Shared mem_sys input bus types and constants for the memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W   = 32;
  localparam int MEM_OFFSET_W = 8;
  localparam int MEM_DATA_W   = 32;

  // Width of the per-grant hold counter; MAX_HOLD must fit below its ceiling.
  localparam int HOLD_CNT_W = 8;

  // Mode 2'b00 means no memory operation: the bus is parked.
  localparam logic [1:0] MEM_MODE_IDLE = 2'b00;

  typedef struct packed {
    logic [1:0]              mode;
    logic [MEM_ADDR_W-1:0]   address;
    logic [MEM_OFFSET_W-1:0] offset;
    logic [MEM_DATA_W-1:0]   data;
  } mem_in_bus_t;

  localparam mem_in_bus_t MEM_IDLE_BUS = '{
    mode:    MEM_MODE_IDLE,
    address: '0,
    offset:  '0,
    data:    '0
  };

  // Next round-robin start point after granting index k (k >= 1);
  // index 0 is never part of the rotation, so the wrap lands on 1.
  function automatic logic [2:0] rr_advance(input logic [2:0] k, input int n_req);
    return (k == 3'(n_req - 1)) ? 3'd1 : k + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Winner selection: index 0 strict priority, else round-robin over 1..N_REQ-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   eligible  requesters allowed to win this cycle
//   rr_ptr    first index (1..N_REQ-1) examined by the rotating scan
//   winner    chosen index, 0 when nothing is eligible
//   valid     a winner exists
module mem_port_arbiter_rr_pick #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [2:0]       rr_ptr,
  output logic [2:0]       winner,
  output logic             valid
);

  int idx;

  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    idx    = 0;
    if (eligible[0]) begin
      valid = 1'b1;
    end else begin
      // Walk rr_ptr, rr_ptr+1, ... wrapping N_REQ-1 -> 1; the first hit wins.
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx = ((int'(rr_ptr) - 1 + k) % (N_REQ - 1)) + 1;
        if (!valid && eligible[idx]) begin
          valid  = 1'b1;
          winner = 3'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the mem_sys input port between N_REQ requesters with a registered grant.
// Latency: grant 1 cycle after req; handover between owners with zero idle cycles.
// Backpressure: requesters wait on gnt; an owner is never preempted, only timed out.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   req           per-requester request level, held for the whole transaction
//   req_bus       per-requester mem_sys input bus
//   gnt           registered one-hot grant, zero when idle
//   mem_in        bus driven to mem_sys (idle bus when nobody owns the port)
//   owner         index of the current owner, 0 when idle
//   busy          OR of gnt
//   timeout_err   sticky: some owner exceeded MAX_HOLD cycles
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  mem_in_bus_t [N_REQ-1:0] req_bus,
  output logic [N_REQ-1:0]        gnt,
  output mem_in_bus_t             mem_in,
  output logic [2:0]              owner,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  // The IDLE / OWNED(i) state is carried entirely by gnt: zero is IDLE,
  // a single set bit i is OWNED(i).
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [N_REQ-1:0]      mask;
  logic [2:0]            rr_ptr;

  logic                  own_req;
  logic                  hold_limit;
  logic                  stay;
  logic                  timeout;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      mask_nx;
  logic [N_REQ-1:0]      gnt_nx;
  logic [2:0]            pick_idx;
  logic                  pick_vld;

  assign busy       = |gnt;
  assign own_req    = |(req & gnt);
  assign hold_limit = (hold_cnt >= HOLD_LAST);
  assign stay       = own_req & ~hold_limit;
  assign timeout    = own_req & hold_limit;

  // A timed-out owner sits out the arbitration on the edge it is revoked,
  // and stays masked until it lets go of req at least once.
  assign eligible = req & ~mask & ~(timeout ? gnt : '0);
  assign mask_nx  = (mask & req) | (timeout ? gnt : '0);

  mem_port_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (pick_idx),
    .valid    (pick_vld)
  );

  always_comb begin
    gnt_nx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_nx[i] = pick_vld && (pick_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt         <= '0;
      owner       <= 3'd0;
      hold_cnt    <= '0;
      mask        <= '0;
      rr_ptr      <= 3'd1;
      timeout_err <= 1'b0;
    end else begin
      mask <= mask_nx;
      if (timeout) begin
        timeout_err <= 1'b1;
      end
      if (stay) begin
        if (hold_cnt != '1) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        // Idle, release or timeout: re-arbitrate on this same edge.
        hold_cnt <= '0;
        gnt      <= gnt_nx;
        owner    <= pick_vld ? pick_idx : 3'd0;
        if (pick_vld && pick_idx != 3'd0) begin
          rr_ptr <= rr_advance(pick_idx, N_REQ);
        end
      end
    end
  end

  // Driven from the registered grant only, so an async reset parks the bus at once.
  always_comb begin
    mem_in = MEM_IDLE_BUS;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mem_in = req_bus[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int MH = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N-1:0]        req;
  mem_in_bus_t [N-1:0] req_bus;
  logic [N-1:0]        gnt;
  mem_in_bus_t         mem_in;
  logic [2:0]          owner;
  logic                busy;
  logic                timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner index (-1 idle), cycles held, masks, rr start, sticky error.
  int m_owner;
  int m_hold;
  bit m_mask [N];
  int m_rr;
  bit m_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_bus     (req_bus),
    .gnt         (gnt),
    .mem_in      (mem_in),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_in.mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", mem_in.mode); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
    req_bus[1] = '{mode: 2'b01, address: 32'h5555, offset: 8'h11, data: 32'hA1A1A1A1};
    req = 3'b010;
    cyc();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL first_gnt: got %b expected 010", gnt); end
    checks++; if (owner !== 3'd1) begin errors++; $display("FAIL first_owner: got %0d expected 1", owner); end
    checks++; if (mem_in.address !== 32'h5555) begin errors++; $display("FAIL first_addr: got %h expected 5555", mem_in.address); end
  endtask

  task automatic test_back_to_back();
    req_bus[2] = '{mode: 2'b01, address: 32'h2222, offset: 8'h22, data: 32'h76767676};
    req = 3'b110;
    cyc();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL b2b_hold: got %b expected 010", gnt); end
    req = 3'b100;
    cyc();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL b2b_gnt: got %b expected 100", gnt); end
    checks++; if (mem_in.data !== 32'h76767676) begin errors++; $display("FAIL b2b_data: got %h expected 76767676", mem_in.data); end
  endtask

  task automatic test_priority();
    req = 3'b101;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL no_preempt_%0d: got %b expected 100", i, gnt); end
    end
    req = 3'b001;
    cyc();
    checks++; if (gnt !== 3'b001 || owner !== 3'd0) begin errors++; $display("FAIL prio_after_release: got gnt %b owner %0d expected 001 owner 0", gnt, owner); end
    req = 3'b000;
    cyc();
    checks++; if (gnt !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL prio_idle: got gnt %b busy %b expected 000 0", gnt, busy); end
    req = 3'b111;
    cyc();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL prio_all: got %b expected 001", gnt); end
    // Grants so far were 1 then 2, so the rotation restarts at 1.
    req = 3'b110;
    cyc();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL prio_then_rr: got %b expected 010", gnt); end
    req = 3'b000;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    req = 3'b110;
    for (int r = 0; r < 4; r++) begin
      exp = (r % 2 == 0) ? 3'b010 : 3'b100;
      cyc();
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_round%0d_a: got %b expected %b", r, gnt, exp); end
      req = 3'b110;
      cyc();
      checks++; if (gnt !== exp) begin errors++; $display("FAIL rr_round%0d_b: got %b expected %b", r, gnt, exp); end
      req = 3'b110 & ~exp;
    end
    req = 3'b000;
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b010;
    for (int i = 0; i < MH; i++) begin
      cyc();
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL to_held_%0d: got %b expected 010", i, gnt); end
    end
    cyc();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL to_revoke: got %b expected 000", gnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", timeout_err); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL to_masked_%0d: got %b expected 000", i, gnt); end
    end
    req = 3'b000;
    cyc();
    req = 3'b010;
    cyc();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL to_regrant: got %b expected 010", gnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    req = 3'b000;
    cyc();
  endtask

  task automatic test_reset_mid_grant();
    req_bus[2] = '{mode: 2'b01, address: 32'h3030, offset: 8'h33, data: 32'h13131313};
    req = 3'b100;
    cyc();
    checks++; if (gnt !== 3'b100 || mem_in.data !== 32'h13131313) begin errors++; $display("FAIL mid_pre: got gnt %b data %h expected 100 13131313", gnt, mem_in.data); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL mid_gnt: got %b expected 000", gnt); end
    checks++; if (mem_in.mode !== 2'b00) begin errors++; $display("FAIL mid_mode: got %b expected 00", mem_in.mode); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", timeout_err); end
    req = 3'b000;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic model_edge();
    int w;
    int excl;
    int c;
    if (m_owner >= 0 && req[m_owner] && m_hold < MH - 1) begin
      m_hold++;
    end else begin
      excl = -1;
      if (m_owner >= 0 && req[m_owner]) begin
        m_err = 1'b1;
        excl  = m_owner;
      end
      w = -1;
      if (req[0] && !m_mask[0] && excl != 0) begin
        w = 0;
      end else begin
        for (int k = 0; k < N - 1; k++) begin
          c = ((m_rr - 1 + k) % (N - 1)) + 1;
          if (w < 0 && req[c] && !m_mask[c] && c != excl) w = c;
        end
      end
      if (excl >= 0) m_mask[excl] = 1'b1;
      m_owner = w;
      m_hold  = 0;
      if (w >= 1) m_rr = (w == N - 1) ? 1 : w + 1;
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i]) m_mask[i] = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_gnt;
    mem_in_bus_t  exp_bus;
    logic [2:0]   exp_owner;
    do_reset();
    m_owner = -1;
    m_hold  = 0;
    m_rr    = 1;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(i == 0 ? 7 : 3) == 0) req[i] = ~req[i];
        req_bus[i].mode    = 2'($urandom_range(3));
        req_bus[i].address = $urandom;
        req_bus[i].offset  = 8'($urandom);
        req_bus[i].data    = $urandom;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      exp_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      exp_bus   = (m_owner >= 0) ? req_bus[m_owner] : MEM_IDLE_BUS;
      exp_owner = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt t=%0d: got %b expected %b", t, gnt, exp_gnt); end
      checks++; if (owner !== exp_owner || busy !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_owner t=%0d: got %0d busy %b expected %0d", t, owner, busy, exp_owner); end
      checks++; if (mem_in !== exp_bus) begin errors++; $display("FAIL rnd_bus t=%0d: got %h expected %h", t, mem_in, exp_bus); end
      checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd_err t=%0d: got %b expected %b", t, timeout_err, m_err); end
    end
    req = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = '0;
    req_bus = '0;
    test_reset();
    test_back_to_back();
    test_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
